// File: rtl/atm_db_arbiter_pkg.sv
// rtl/atm_db_arbiter_pkg.sv - shared op codes, FSM states, status constants and defaults for atm_db_arbiter
package atm_db_arbiter_pkg;

  typedef enum logic [1:0] {
    OP_BALANCE  = 2'b00,
    OP_WITHDRAW = 2'b01,
    OP_DEPOSIT  = 2'b10,
    OP_RESERVED = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int NUM_ACCOUNTS_DEFAULT = 10;

endpackage

// File: rtl/atm_db_arbiter_rr_arbiter.sv
// rtl/atm_db_arbiter_rr_arbiter.sv - first-request-at-or-after-pointer select with registered round-robin pointer
module atm_db_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  input  logic [IW-1:0]      winner,
  output logic               valid,
  output logic [IW-1:0]      sel
);

  logic [IW-1:0] ptr;

  // Scan from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[IW'(j)]) begin
        valid = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: rtl/atm_db_arbiter.sv
// rtl/atm_db_arbiter.sv - round-robin atomic read-modify-write access to the balance database
// Optional WITHDRAW_LIMIT_EN: rejects withdrawals above MAX_WITHDRAW before the funds check.
module atm_db_arbiter
  import atm_db_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int NUM_ACCOUNTS = NUM_ACCOUNTS_DEFAULT
`ifdef WITHDRAW_LIMIT_EN
  ,
  parameter logic [31:0] MAX_WITHDRAW = 32'd5000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [4*NUM_REQ-1:0]  req_acc,
  input  logic [32*NUM_REQ-1:0] req_amount,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    done,
  output logic                  ok,
  output logic [31:0]           result_balance,
  output logic [3:0]            mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           mem_wdata,
  output logic                  mem_we
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0] ACC_LIMIT = 5'(NUM_ACCOUNTS);

  state_e        state_q, state_d;
  op_e           op_q;
  logic          acc_valid_q;
  logic [31:0]   amt_q;
  logic [IW-1:0] win_q, arb_sel;
  logic          arb_valid;
  logic [3:0]    sel_acc;
  logic          exec_ok, exec_we, over_limit;
  logic [31:0]   exec_res, exec_wdata;
  logic [32:0]   sum;

  atm_db_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (state_q == ST_RESP),
    .winner  (win_q),
    .valid   (arb_valid),
    .sel     (arb_sel)
  );

  assign sel_acc = req_acc[4*arb_sel +: 4];

  // Balance arrives on mem_rdata during EXEC; everything below is only consumed then.
  always_comb begin
    sum = {1'b0, mem_rdata} + {1'b0, amt_q};
`ifdef WITHDRAW_LIMIT_EN
    over_limit = amt_q > MAX_WITHDRAW;
`else
    over_limit = 1'b0;
`endif
    exec_ok    = FALSE;
    exec_res   = mem_rdata;
    exec_we    = 1'b0;
    exec_wdata = '0;
    if (!acc_valid_q) begin
      exec_res = '0;
    end else begin
      case (op_q)
        OP_BALANCE: exec_ok = TRUE;
        OP_WITHDRAW: begin
          if (!over_limit && amt_q <= mem_rdata) begin
            exec_ok    = TRUE;
            exec_we    = 1'b1;
            exec_wdata = mem_rdata - amt_q;
            exec_res   = mem_rdata - amt_q;
          end
        end
        OP_DEPOSIT: begin
          if (!sum[32]) begin
            exec_ok    = TRUE;
            exec_we    = 1'b1;
            exec_wdata = sum[31:0];
            exec_res   = sum[31:0];
          end
        end
        default: exec_ok = FALSE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: if (arb_valid) state_d = ST_RD;
      ST_RD:   state_d = ST_EXEC;
      ST_EXEC: begin
        state_d   = ST_RESP;
        mem_we    = exec_we;
        mem_wdata = exec_we ? exec_wdata : '0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt            <= '0;
      done           <= '0;
      ok             <= 1'b0;
      result_balance <= '0;
      mem_addr       <= '0;
      win_q          <= '0;
      op_q           <= OP_BALANCE;
      acc_valid_q    <= 1'b0;
      amt_q          <= '0;
    end else begin
      done <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            win_q       <= arb_sel;
            gnt         <= NUM_REQ'(1) << arb_sel;
            op_q        <= op_e'(req_op[2*arb_sel +: 2]);
            amt_q       <= req_amount[32*arb_sel +: 32];
            acc_valid_q <= {1'b0, sel_acc} < ACC_LIMIT;
            mem_addr    <= ({1'b0, sel_acc} < ACC_LIMIT) ? sel_acc : 4'd0;
          end
        end
        ST_EXEC: begin
          done           <= gnt;
          ok             <= exec_ok;
          result_balance <= exec_res;
        end
        ST_RESP: gnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_db_arbiter.sv
// tb/tb_atm_db_arbiter.sv - scoreboard bench for atm_db_arbiter against a transaction-level model
module tb_atm_db_arbiter;

  localparam int N    = 4;
  localparam int NACC = 10;
  localparam logic [31:0] MAXW = 32'd5000;
`ifdef WITHDRAW_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  typedef struct { int id; int op; int acc; logic [31:0] amt; int start; } txn_t;
  typedef struct { int id; logic ok; logic [31:0] res; bit chk_res; bit abort; int gfirst; int glast; int endc; } exp_t;
  typedef struct { logic [3:0] addr; logic [31:0] data; int cyc; } wexp_t;
  typedef struct { int addr; logic [31:0] data; } mchk_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [2*N-1:0]  req_op;
  logic [4*N-1:0]  req_acc;
  logic [32*N-1:0] req_amount;
  logic [N-1:0]    gnt, done;
  logic            ok;
  logic [31:0]     result_balance;
  logic [3:0]      mem_addr;
  logic [31:0]     mem_rdata;
  logic [31:0]     mem_wdata;
  logic            mem_we;

  atm_db_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_acc(req_acc),
    .req_amount(req_amount), .gnt(gnt), .done(done), .ok(ok),
    .result_balance(result_balance), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Balance memory with one-cycle read latency and a bench-only load port.
  logic [31:0] mem [0:15];
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  always @(posedge clk) begin
    if (load_en)     mem[load_addr] <= load_data;
    else if (mem_we) mem[mem_addr]  <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  exp_t        sb[$];
  wexp_t       wq[$];
  mchk_t       mchk[$];
  txn_t        batch[$];
  logic [31:0] model_db [0:15];
  int          model_ptr = 0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input bit pass, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!pass) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [N-1:0] eg, ed;
    logic ew;
    eg = '0;
    ed = '0;
    ew = 1'b0;
    if (sb.size() > 0) begin
      if (cyc >= sb[0].gfirst && cyc <= sb[0].glast) eg = N'(1) << sb[0].id;
      if (cyc == sb[0].endc && !sb[0].abort) ed = N'(1) << sb[0].id;
    end
    if (wq.size() > 0 && wq[0].cyc == cyc) ew = 1'b1;
    check(gnt === eg, "gnt", 32'(gnt), 32'(eg));
    check(done === ed, "done", 32'(done), 32'(ed));
    check(mem_we === ew, "mem_we", 32'(mem_we), 32'(ew));
    if (ed != '0 && done === ed) begin
      check(ok === sb[0].ok, "ok", 32'(ok), 32'(sb[0].ok));
      if (sb[0].chk_res) check(result_balance === sb[0].res, "result_balance", result_balance, sb[0].res);
    end
    if (ew && mem_we === 1'b1) begin
      check(mem_addr === wq[0].addr, "mem_addr", 32'(mem_addr), 32'(wq[0].addr));
      check(mem_wdata === wq[0].data, "mem_wdata", mem_wdata, wq[0].data);
    end
    if (ew) void'(wq.pop_front());
    if (sb.size() > 0 && cyc == sb[0].endc) void'(sb.pop_front());
    if (rst === 1'b0) begin
      check(ok === 1'b0, "reset_ok", 32'(ok), 32'd0);
      check(result_balance === '0, "reset_result", result_balance, 32'd0);
      check(mem_addr === '0, "reset_mem_addr", 32'(mem_addr), 32'd0);
      check(mem_wdata === '0, "reset_mem_wdata", mem_wdata, 32'd0);
    end
    while (mchk.size() > 0) begin
      check(mem[mchk[0].addr] === mchk[0].data, "db_contents", mem[mchk[0].addr], mchk[0].data);
      void'(mchk.pop_front());
    end
  end

  task automatic preload(input int a, input logic [31:0] d);
    load_addr = 4'(a);
    load_data = d;
    load_en   = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
    model_db[a] = d;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_ptr = 0;
  endtask

  task automatic add(input int id, input int op, input int acc, input logic [31:0] amt);
    txn_t t;
    t.id = id; t.op = op; t.acc = acc; t.amt = amt; t.start = 0;
    batch.push_back(t);
  endtask

  // Reference rules of one transaction applied to the model database.
  task automatic predict(input txn_t t, output exp_t e, output bit wv, output wexp_t wx);
    logic [31:0] bal;
    longint sum;
    e.id = t.id; e.ok = 1'b0; e.res = '0; e.chk_res = 1'b1; e.abort = 1'b0;
    e.gfirst = 0; e.glast = 0; e.endc = 0;
    wv = 1'b0; wx.addr = 4'(t.acc); wx.data = '0; wx.cyc = 0;
    if (t.acc < NACC) begin
      bal   = model_db[t.acc];
      e.res = bal;
      case (t.op)
        0: e.ok = 1'b1;
        1: if (!(LIMIT && t.amt > MAXW) && t.amt <= bal) begin
             e.ok = 1'b1; e.res = bal - t.amt; wv = 1'b1;
           end
        2: begin
             sum = longint'(bal) + longint'(t.amt);
             if (sum <= 64'hFFFF_FFFF) begin
               e.ok = 1'b1; e.res = sum[31:0]; wv = 1'b1;
             end
           end
        default: e.chk_res = 1'b0;
      endcase
      if (wv) begin
        wx.data = e.res;
        model_db[t.acc] = e.res;
      end
    end
  endtask

  // Serve the batch in round-robin order; each requester re-requests until its items are exhausted.
  task automatic run_batch();
    txn_t  sched[$];
    txn_t  t;
    exp_t  e;
    wexp_t wx;
    bit    wv, found;
    int    c0, k, w, idx, last;
    c0 = cyc;
    k  = 0;
    while (batch.size() > 0) begin
      w = -1;
      idx = 0;
      for (int s = 0; s < N && w < 0; s++)
        for (int i = 0; i < batch.size() && w < 0; i++)
          if (batch[i].id == (model_ptr + s) % N) begin
            w = batch[i].id;
            idx = i;
          end
      t = batch[idx];
      batch.delete(idx);
      t.start = c0 + 4 * k;
      predict(t, e, wv, wx);
      e.gfirst = t.start + 1;
      e.glast  = t.start + 3;
      e.endc   = t.start + 3;
      sb.push_back(e);
      if (wv) begin
        wx.cyc = t.start + 2;
        wq.push_back(wx);
      end
      sched.push_back(t);
      model_ptr = (w + 1) % N;
      k++;
    end
    last = c0 + 4 * k;
    for (int cy = c0; cy <= last; cy++) begin
      for (int r = 0; r < N; r++) begin
        found = 1'b0;
        for (int i = 0; i < sched.size(); i++)
          if (!found && sched[i].id == r && sched[i].start + 3 >= cy) begin
            found = 1'b1;
            req_op[2*r +: 2]      = 2'(sched[i].op);
            req_acc[4*r +: 4]     = 4'(sched[i].acc);
            req_amount[32*r +: 32] = sched[i].amt;
          end
        req[r] = found;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int c0, acc, n;
    logic [31:0] amt;
    exp_t e;
    rst = 1'b1;
    req = '0; req_op = '0; req_acc = '0; req_amount = '0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int a = 0; a < 16; a++) preload(a, 32'(1000 + 10 * a));
    rst = 1'b1;
    model_ptr = 0;

    preload(3, 32'd4000);
    add(0, 0, 3, 32'd0);
    run_batch();

    preload(1, 32'd2000);
    add(0, 1, 1, 32'd1500);
    add(0, 1, 1, 32'd600);
    run_batch();

    preload(5, 32'hFFFF_FFFF);
    preload(6, 32'd1000);
    add(0, 2, 5, 32'd1);
    add(1, 2, 6, 32'd250);
    run_batch();

    apply_reset();
    preload(7, 32'd1000);
    for (int r = 0; r < N; r++) add(r, 2, 7, 32'd100);
    add(0, 0, 7, 32'd0);
    run_batch();
    mchk.push_back('{7, 32'd1400});

    add(2, 1, 12, 32'd5);
    run_batch();

    // Withdraw aborted by reset during its EXEC cycle.
    preload(2, 32'd3000);
    c0 = cyc;
    req[1] = 1'b1; req_op[3:2] = 2'b01; req_acc[7:4] = 4'd2; req_amount[63:32] = 32'd100;
    e.id = 1; e.ok = 1'b0; e.res = '0; e.chk_res = 1'b0; e.abort = 1'b1;
    e.gfirst = c0 + 1; e.glast = c0 + 1; e.endc = c0 + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    @(posedge clk); #1;
    apply_reset();
    mchk.push_back('{2, 32'd3000});

    preload(9, 32'd10000);
    add(3, 1, 9, 32'd6000);
    run_batch();

    for (int b = 0; b < 40; b++) begin
      for (int p = 0; p < 2; p++)
        preload($urandom_range(0, NACC - 1), ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20000)));
      for (int r = 0; r < N; r++) begin
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
          acc = ($urandom_range(0, 7) == 0) ? $urandom_range(NACC, 15) : $urandom_range(0, NACC - 1);
          case ($urandom_range(0, 3))
            0: amt = 32'($urandom_range(0, 1500));
            1: amt = 32'($urandom_range(0, 8000));
            2: amt = $urandom;
            default: amt = 32'($urandom_range(4990, 5010));
          endcase
          add(r, $urandom_range(0, 3), acc, amt);
        end
      end
      run_batch();
      if ($urandom_range(0, 9) == 0) apply_reset();
    end

    for (int a = 0; a < 16; a++) mchk.push_back('{a, model_db[a]});
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_db_arbiter.md
Name: atm_db_arbiter

Overview:
- Shares the single-port account balance database between NUM_REQ ATM terminal front-ends.
- Round-robin arbitration; each granted transaction is an atomic read-modify-write (balance inquiry, withdraw, deposit), so concurrent terminals can never corrupt a balance.
- Sits between the per-terminal ATM controllers and the balance memory; owns all memory read/write sequencing.

Parameters:
- NUM_REQ, 4, number of terminal requesters (2..8)
- NUM_ACCOUNTS, 10, valid account indices 0..NUM_ACCOUNTS-1
- MAX_WITHDRAW, 5000, per-transaction withdraw ceiling (used only with WITHDRAW_LIMIT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-terminal request; held high until done
- req_op  in  2*NUM_REQ  per-terminal op: 00 BALANCE, 01 WITHDRAW, 10 DEPOSIT, 11 reserved
- req_acc  in  4*NUM_REQ  per-terminal account index
- req_amount  in  32*NUM_REQ  per-terminal amount
- gnt  out  NUM_REQ  one-hot grant, high for the whole transaction
- done  out  NUM_REQ  one-cycle completion pulse to the granted terminal
- ok  out  1  result status, valid while done!=0
- result_balance  out  32  post-transaction balance, valid while done!=0
- mem_addr  out  4  database address
- mem_rdata  in  32  database read data, 1-cycle synchronous read latency
- mem_wdata  out  32  database write data
- mem_we  out  1  database write enable

Behaviour:
- Reset: asserting rst (low) clears gnt, done, ok, result_balance, mem_addr, mem_wdata and mem_we to 0. FSM goes to IDLE; the round-robin pointer goes to 0 (requester 0 has highest priority).
- FSM states: IDLE -> RD -> EXEC -> RESP -> IDLE.
  - IDLE: if any req is high, select the first requester at or after the pointer, wrapping modulo NUM_REQ. Latch its op, account and amount. Register gnt and mem_addr=acc. Go to RD. With no requests, stay in IDLE.
  - RD: wait one cycle for mem_rdata.
  - EXEC: capture rdata as bal, then compute:
    - BALANCE: ok=1, result=bal, no write.
    - WITHDRAW: if amount>bal, ok=0, result=bal, no write. Else mem_we=1 for exactly one cycle, mem_wdata=bal-amount, ok=1.
    - DEPOSIT: compute a 33-bit sum. If bit32 is set, ok=0, result=bal, no write (overflow). Else write the sum, ok=1.
    - reserved op: ok=0, no write.
  - RESP: done[winner]=1 for one cycle, with ok and result_balance valid. gnt drops at the end of RESP. The pointer moves to winner+1 (wraps).
- Latency: req seen in IDLE at cycle 0; gnt high in cycles 1-3; mem_we (if any) in cycle 2; done in cycle 3. The next grant is issued no earlier than cycle 4. Max throughput is 1 transaction per 4 cycles.
- Invalid account (acc >= NUM_ACCOUNTS): the FSM still walks all states, but mem_addr is held at 0 and mem_we is never asserted. Result is ok=0, result_balance=0.
- Requester lowering req mid-transaction: the transaction still completes and writes; done is still pulsed.
- Simultaneous requests: strictly round-robin. No requester waits more than NUM_REQ-1 transactions.
- Reset mid-transaction: abort immediately. No write is issued after reset assertion and no done pulse is produced.
- ok and result_balance hold their last values outside done. Verification checks them only while done!=0.

Optional Feature:
- WITHDRAW_LIMIT_EN defined: a WITHDRAW with amount > MAX_WITHDRAW is rejected in EXEC with ok=0, result=bal, no write. This check has priority over the funds check.
- Not defined: there is no ceiling; only the insufficient-funds check applies.

Decomposition:
- Shared definitions package/include:
  - op codes (OP_BALANCE, OP_WITHDRAW, OP_DEPOSIT)
  - FSM state encodings
  - TRUE/FALSE status constants
  - the NUM_ACCOUNTS default
- One natural sub-module, rr_arbiter: combinational first-set-at-or-after-pointer select plus the registered pointer update. The top holds the FSM and the RMW datapath.

Test Plan:
- Single BALANCE on acc 3 (db[3]=4000) from req0 -> gnt0 cycles 1-3, no mem_we, done0 at cycle 3, ok=1, result=4000.
- WITHDRAW 1500 from acc 1 (2000) -> mem_we once with wdata=500; ok=1, result=500. A following WITHDRAW 600 -> ok=0, result=500, no write.
- DEPOSIT 1 on an account holding 32'hFFFFFFFF -> ok=0, no write. DEPOSIT 250 on 1000 -> write 1250, ok=1.
- req0-req3 asserted together, each re-requesting immediately -> grant order 0,1,2,3,0. Each done is exactly 4 cycles apart. Concurrent DEPOSIT 100 ×4 on the same acc (1000) ends at 1400.
- Account 12 from req2 -> done2, ok=0, result=0, mem_we never high. rst pulled low in cycle 2 of a WITHDRAW -> no mem_we, no done, all outputs 0.
- WITHDRAW_LIMIT_EN defined: WITHDRAW 6000 on acc 9 (10000) -> ok=0, no write. Not defined: the same stimulus gives ok=1, result=4000.
